regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register file for the next-generation MIPS datapath.
//  - NUM_RD combinational read ports and two write ports (WB0 = ALU, WB1 = load).
//  - Register 0 is hard-wired to zero; optional write-to-read bypass.
//  - Per-register busy scoreboard so the pipelined core can detect RAW hazards.
//  Sits between the decode stage (reads, busy checks) and writeback (writes).
// PARAMETERS
//  DW      32  data width in bits
//  DEPTH   32  number of registers (power of 2, >=2)
//  AW      $clog2(DEPTH)  address width (derived, not overridable)
//  NUM_RD  2   read ports (1..4)
//  BYPASS  1   1: a same-cycle write is visible on the read port; 0: it is not
// PORTS
//  clk            in   1            rising-edge clock
//  rst_n          in   1            asynchronous active-low reset
//  rd_addr        in   NUM_RD*AW    packed read addresses, port i at [i*AW +: AW]
//  rd_data        out  NUM_RD*DW    packed read data, port i at [i*DW +: DW]
//  rd_busy        out  NUM_RD       1 = rd_addr[i] has a pending producer
//  wr_en          in   2            per-port write enable
//  wr_addr        in   2*AW         packed write addresses
//  wr_data        in   2*DW         packed write data
//  busy_set       in   1            decode issued an instruction that writes busy_addr
//  busy_addr      in   AW           destination register being reserved
//  busy_any       out  1            OR of all busy bits (drain/flush check)
// BEHAVIOUR
//  Reset (rst_n=0, async): all registers = 0 and all busy bits = 0 immediately.
//   - Outputs follow: rd_data = 0, rd_busy = 0, busy_any = 0.
//   - Release is synchronous to clk; the first write is accepted on the first
//     rising edge with rst_n=1.
//  Reads: combinational, zero latency.
//   - rd_addr==0 returns 0 with rd_busy=0 regardless of any other input.
//   - BYPASS=1: if wr_en[p] and wr_addr[p]==rd_addr[i]!=0, rd_data[i]=wr_data[p]
//     in the same cycle; port 1 takes priority over port 0.
//   - BYPASS=0: the read returns the stored value; new data is visible the
//     cycle after the edge.
//  Writes: on posedge clk, reg[wr_addr[p]] <= wr_data[p] for each enabled port.
//   - Writes to address 0 are dropped.
//   - Both ports to the same address: port 1 (load) wins, port 0 is discarded.
//  Busy scoreboard, per register r != 0, evaluated on posedge clk:
//   - Cleared when any enabled write port targets r.
//   - Set when busy_set && busy_addr==r.
//   - Set and clear in the same cycle: the set wins (a new producer was issued).
//   - busy_set with busy_addr==0 is ignored; busy bit 0 is constant 0.
//  rd_busy[i] = busy[rd_addr[i]]; with BYPASS=1 it is forced to 0 when a
//   same-cycle write to that address is being bypassed.
//  Out-of-range addresses cannot occur because DEPTH is a power of 2.
//  All behaviour is fully synchronous apart from reset; no X on any output after reset.
// STRUCTURE
//  Shared package mips_pkg:
//   - DW and DEPTH defaults.
//   - WB_ALU=0 and WB_LOAD=1 port index constants.
//   - typedef reg_addr_t.
//  One sub-module, regfile_rd_port: a single read mux plus bypass/zero logic,
//   instantiated NUM_RD times in a generate loop.
//  Storage is a flop array (the reset requirement rules out RAM inference).
//  The busy vector is a DEPTH-bit register in the top module.
// TESTING
//  1 Reset: assert rst_n=0 mid-run after writing r5=0xDEADBEEF
//    -> rd_data=0 for r5 and rd_busy=0 immediately, without waiting for a clk edge.
//  2 Zero reg: write r0=0xFFFFFFFF via both ports, then busy_set r0
//    -> reading r0 returns 0, rd_busy=0, busy_any=0.
//  3 Bypass: BYPASS=1, wr_en=01, r7<=0x12345678, rd_addr0=7 in the same cycle
//    -> rd_data0=0x12345678 that cycle. With BYPASS=0, the old value that cycle
//    and the new value on the next cycle.
//  4 Write collision: both ports write r9, port0=0x1111, port1=0x2222
//    -> r9 reads 0x2222 after the edge.
//  5 Scoreboard: busy_set r3 -> rd_busy=1 next cycle; wr_en r3 -> busy clears
//    the cycle after. Simultaneous busy_set r3 and write r3 -> busy stays 1
//    and the data is updated.
//  6 Random: 10k cycles against a reference model, NUM_RD=3, DEPTH=16.
//    Check every read port and busy_any each cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: default widths,
// writeback port indices and the register address type.
package mips_pkg;

    localparam int DW_DEF    = 32;
    localparam int DEPTH_DEF = 32;
    localparam int AW_DEF    = $clog2(DEPTH_DEF);

    // Writeback port indices: ALU results and load data
    localparam int WB_ALU  = 0;
    localparam int WB_LOAD = 1;

    typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational register-file read port with r0 forcing and
// optional write bypass.
// Ports: rd_addr in, regs/busy (storage view) in, wr_* (bypass
// sources) in, rd_data/rd_busy out.
module regfile_rd_port
    import mips_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0]             rd_addr,
    input  logic [DEPTH-1:0][DW-1:0]  regs,
    input  logic [DEPTH-1:0]          busy,
    input  logic [1:0]                wr_en,
    input  logic [1:0][AW-1:0]        wr_addr,
    input  logic [1:0][DW-1:0]        wr_data,
    output logic [DW-1:0]             rd_data,
    output logic                      rd_busy
);

    always_comb begin
        rd_data = regs[rd_addr];
        rd_busy = busy[rd_addr];
        if (BYPASS != 0) begin
            // Load port is checked last so it overrides the ALU port
            if (wr_en[WB_ALU] && wr_addr[WB_ALU] == rd_addr) begin
                rd_data = wr_data[WB_ALU];
                rd_busy = 1'b0;
            end
            if (wr_en[WB_LOAD] && wr_addr[WB_LOAD] == rd_addr) begin
                rd_data = wr_data[WB_LOAD];
                rd_busy = 1'b0;
            end
        end
        if (rd_addr == '0) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD read ports, ALU + load write
// ports, r0 hard-wired to zero and a per-register busy scoreboard.
// Ports: clk, rst_n; rd_addr/rd_data/rd_busy (packed per port);
// wr_en/wr_addr/wr_data (2 ports); busy_set/busy_addr; busy_any.
module regfile_mp
    import mips_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD*DW-1:0] rd_data,
    output logic [NUM_RD-1:0]    rd_busy,
    input  logic [1:0]           wr_en,
    input  logic [2*AW-1:0]      wr_addr,
    input  logic [2*DW-1:0]      wr_data,
    input  logic                 busy_set,
    input  logic [AW-1:0]        busy_addr,
    output logic                 busy_any
);

    logic [1:0][AW-1:0]         wa;
    logic [1:0][DW-1:0]         wd;
    logic [1:0]                 byp_en;
    logic [NUM_RD-1:0][AW-1:0]  ra;
    logic [NUM_RD-1:0][DW-1:0]  rd;
    logic [DEPTH-1:0][DW-1:0]   regs;
    logic [DEPTH-1:0]           busy;

    assign wa      = wr_addr;
    assign wd      = wr_data;
    assign ra      = rd_addr;
    assign rd_data = rd;

    // Bypass is suppressed during reset so every read returns zero
    assign byp_en  = wr_en & {2{rst_n}};

    assign busy_any = |busy;

    // Entry 0 is only ever reset, so it stays zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else begin
            for (int r = 1; r < DEPTH; r++) begin
                if (wr_en[WB_LOAD] && wa[WB_LOAD] == AW'(r)) begin
                    regs[r] <= wd[WB_LOAD];
                end else if (wr_en[WB_ALU] && wa[WB_ALU] == AW'(r)) begin
                    regs[r] <= wd[WB_ALU];
                end
            end
        end
    end

    // A new reservation beats the completion of the older producer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            for (int r = 1; r < DEPTH; r++) begin
                if (busy_set && busy_addr == AW'(r)) begin
                    busy[r] <= 1'b1;
                end else if ((wr_en[0] && wa[0] == AW'(r)) ||
                             (wr_en[1] && wa[1] == AW'(r))) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_rd_port #(
            .DW     (DW),
            .DEPTH  (DEPTH),
            .BYPASS (BYPASS)
        ) u_port (
            .rd_addr (ra[i]),
            .regs    (regs),
            .busy    (busy),
            .wr_en   (byp_en),
            .wr_addr (wa),
            .wr_data (wd),
            .rd_data (rd[i]),
            .rd_busy (rd_busy[i])
        );
    end

endmodule
